// File: rtl/replay_control.sv
`default_nettype none
// ============================================================================
// Module      : replay_control
// Description : Register-file recovery controller. An error starts a sweep
//               of replay addresses, PORTS lanes per beat under valid/ready.
//               An error during a sweep restarts it, and too many restarts
//               lock the block in a sticky FATAL state. The controller counts
//               accepted errors with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module replay_control #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REG    = 2**ADDR_WIDTH,
  parameter int PORTS      = 1,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        error_i,
  input  logic                        replay_ready_i,
  output logic                        replay_valid_o,
  output logic [PORTS*ADDR_WIDTH-1:0] replay_addr_o,
  output logic [PORTS-1:0]            replay_en_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        fatal_o,
  output logic [CNT_WIDTH-1:0]        error_count_o
);

  // Retry counter needs at least one bit even when no restarts are allowed.
  localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // Lane index width: base + k can reach almost twice the register count.
  localparam int c_LANE_W  = ADDR_WIDTH + 2;

  localparam logic [c_RETRY_W-1:0]  c_RETRY_MAX = c_RETRY_W'(MAX_RETRY);
  localparam logic [ADDR_WIDTH:0]   c_PORTS     = (ADDR_WIDTH + 1)'(PORTS);
  localparam logic [ADDR_WIDTH:0]   c_NUM_REG   = (ADDR_WIDTH + 1)'(NUM_REG);
  localparam logic [c_LANE_W-1:0]   c_NUM_REG_L = c_LANE_W'(NUM_REG);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPLAY = 2'd1,
    S_DONE   = 2'd2,
    S_FATAL  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]    r_base,  w_base_nxt;
  logic [c_RETRY_W-1:0]   r_retry, w_retry_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt,   w_cnt_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic [ADDR_WIDTH:0]    w_base_step;

  assign w_cnt_inc   = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_base_step = r_base + c_PORTS;

  // State and sweep registers; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_retry <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_retry <= w_retry_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; an error always takes priority over a handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_retry_nxt = r_retry;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (error_i) begin
          w_state_nxt = S_REPLAY;
          w_base_nxt  = '0;
          w_retry_nxt = '0;
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      S_REPLAY: begin
        if (error_i) begin
          w_cnt_nxt = w_cnt_inc;
          if (r_retry >= c_RETRY_MAX) begin
            w_state_nxt = S_FATAL;
          end else begin
            w_base_nxt  = '0;
            w_retry_nxt = r_retry + 1'b1;
          end
        end else if (replay_ready_i) begin
          w_base_nxt = w_base_step;
          if (w_base_step >= c_NUM_REG) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (error_i) begin
          w_state_nxt = S_REPLAY;
          w_base_nxt  = '0;
          w_retry_nxt = '0;
          w_cnt_nxt   = w_cnt_inc;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FATAL: begin
        w_state_nxt = S_FATAL;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign replay_valid_o = (r_state == S_REPLAY);
  assign busy_o         = (r_state == S_REPLAY);
  assign done_o         = (r_state == S_DONE);
  assign fatal_o        = (r_state == S_FATAL);
  assign error_count_o  = r_cnt;

  // Per-lane address decode; lanes past the end of the file are disabled
  // and drive address zero.
  for (genvar k = 0; k < PORTS; k++) begin : g_lane
    logic [c_LANE_W-1:0] w_lane;
    logic                w_en;
    assign w_lane = {1'b0, r_base} + c_LANE_W'(k);
    assign w_en   = (r_state == S_REPLAY) && (w_lane < c_NUM_REG_L);
    assign replay_en_o[k] = w_en;
    assign replay_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH] =
      w_en ? w_lane[ADDR_WIDTH-1:0] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_replay_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_replay_control
// Description : Randomized bench for replay_control with two configurations
//               (single lane, and three lanes with a small counter), each
//               compared every cycle against a sweep-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_replay_control;

  localparam int c_AW   = 5;
  localparam int c_NREG = 32;
  // Configuration A: defaults.
  localparam int c_PA   = 1;
  localparam int c_RA   = 3;
  localparam int c_CA   = 8;
  // Configuration B: three lanes, partial last beat, tiny counter.
  localparam int c_PB   = 3;
  localparam int c_RB   = 1;
  localparam int c_CB   = 3;

  logic clk;
  logic rst;
  logic error_i;
  logic ready_i;

  logic                   a_valid, a_busy, a_done, a_fatal;
  logic [c_PA*c_AW-1:0]   a_addr;
  logic [c_PA-1:0]        a_en;
  logic [c_CA-1:0]        a_cnt;
  logic                   b_valid, b_busy, b_done, b_fatal;
  logic [c_PB*c_AW-1:0]   b_addr;
  logic [c_PB-1:0]        b_en;
  logic [c_CB-1:0]        b_cnt;

  int n_vec;
  int n_err;

  replay_control #(
    .ADDR_WIDTH(c_AW), .NUM_REG(c_NREG), .PORTS(c_PA),
    .MAX_RETRY(c_RA), .CNT_WIDTH(c_CA)
  ) u_dut_a (
    .clk(clk), .rst(rst), .error_i(error_i), .replay_ready_i(ready_i),
    .replay_valid_o(a_valid), .replay_addr_o(a_addr), .replay_en_o(a_en),
    .busy_o(a_busy), .done_o(a_done), .fatal_o(a_fatal),
    .error_count_o(a_cnt)
  );

  replay_control #(
    .ADDR_WIDTH(c_AW), .NUM_REG(c_NREG), .PORTS(c_PB),
    .MAX_RETRY(c_RB), .CNT_WIDTH(c_CB)
  ) u_dut_b (
    .clk(clk), .rst(rst), .error_i(error_i), .replay_ready_i(ready_i),
    .replay_valid_o(b_valid), .replay_addr_o(b_addr), .replay_en_o(b_en),
    .busy_o(b_busy), .done_o(b_done), .fatal_o(b_fatal),
    .error_count_o(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: where the sweep is, whether a completion is pending,
  // whether the block is dead, how many restarts were used, errors counted.
  typedef struct {
    bit sweeping;
    bit done_p;
    bit dead;
    int next;
    int retries;
    int cnt;
  } model_t;

  model_t m_a;
  model_t m_b;

  function automatic model_t model_reset();
    model_t m;
    m.sweeping = 0; m.done_p = 0; m.dead = 0;
    m.next = 0; m.retries = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit err, bit rdy,
                                        int ports, int maxr, int cmax);
    model_t n = m;
    if (m.dead) return n;
    if (m.sweeping) begin
      if (err) begin
        if (n.cnt < cmax) n.cnt++;
        if (m.retries >= maxr) begin
          n.dead = 1; n.sweeping = 0;
        end else begin
          n.retries++; n.next = 0;
        end
      end else if (rdy) begin
        n.next = m.next + ports;
        if (n.next >= c_NREG) begin
          n.sweeping = 0; n.done_p = 1;
        end
      end
    end else begin
      n.done_p = 0;
      if (err) begin
        n.sweeping = 1; n.next = 0; n.retries = 0;
        if (n.cnt < cmax) n.cnt++;
      end
    end
    return n;
  endfunction

  // Expected lane bus: registers next..next+ports-1, out-of-range lanes zero.
  task automatic model_lanes(input model_t m, input int ports,
                             output logic [63:0] addr, output logic [63:0] en);
    addr = '0;
    en   = '0;
    if (m.sweeping) begin
      for (int k = 0; k < ports; k++) begin
        if (m.next + k < c_NREG) begin
          en[k] = 1'b1;
          addr  = addr | (64'(m.next + k) << (k * c_AW));
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] ea, ee;
    model_lanes(m_a, c_PA, ea, ee);
    chk("A.valid", 64'(a_valid), 64'(m_a.sweeping));
    chk("A.busy",  64'(a_busy),  64'(m_a.sweeping));
    chk("A.done",  64'(a_done),  64'(m_a.done_p));
    chk("A.fatal", 64'(a_fatal), 64'(m_a.dead));
    chk("A.addr",  64'(a_addr),  ea);
    chk("A.en",    64'(a_en),    ee);
    chk("A.cnt",   64'(a_cnt),   64'(m_a.cnt));
    model_lanes(m_b, c_PB, ea, ee);
    chk("B.valid", 64'(b_valid), 64'(m_b.sweeping));
    chk("B.busy",  64'(b_busy),  64'(m_b.sweeping));
    chk("B.done",  64'(b_done),  64'(m_b.done_p));
    chk("B.fatal", 64'(b_fatal), 64'(m_b.dead));
    chk("B.addr",  64'(b_addr),  ea);
    chk("B.en",    64'(b_en),    ee);
    chk("B.cnt",   64'(b_cnt),   64'(m_b.cnt));
  endtask

  // One clock: drive at the falling edge, advance the model on the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input bit e, input bit r, input bit rs);
    error_i = e;
    ready_i = r;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      m_a = model_reset();
      m_b = model_reset();
    end else begin
      m_a = model_step(m_a, e, r, c_PA, c_RA, (1 << c_CA) - 1);
      m_b = model_step(m_b, e, r, c_PB, c_RB, (1 << c_CB) - 1);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int issued;
    int guard;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    error_i = 1'b0;
    ready_i = 1'b0;
    m_a = model_reset();
    m_b = model_reset();
    @(negedge clk);

    // Reset values.
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Single error pulse, ready held high: full sweeps on both instances.
    cycle(1, 1, 0);
    for (int i = 0; i < 40; i++) cycle(0, 1, 0);

    // Backpressure: ready alternates each cycle.
    cycle(1, 1, 0);
    for (int i = 0; i < 80; i++) cycle(0, (i % 2) == 0, 0);

    // Restart while address 10 is on instance A.
    cycle(0, 0, 1);
    cycle(1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0);
    chk("A.addr10", 64'(a_addr), 64'd10);
    cycle(1, 1, 0);
    chk("A.restart0", 64'(a_addr), 64'd0);
    chk("A.cnt2", 64'(a_cnt), 64'd2);
    for (int i = 0; i < 40; i++) cycle(0, 1, 0);

    // Reset in the middle of a sweep.
    cycle(1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    cycle(0, 1, 1);
    chk("A.rst_valid", 64'(a_valid), 64'd0);

    // Fatal: continuous errors from idle; four in-replay errors on A.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0);
    chk("A.fatal", 64'(a_fatal), 64'd1);
    chk("A.cnt5", 64'(a_cnt), 64'd5);
    for (int i = 0; i < 6; i++) cycle(1, $urandom_range(0, 1) == 1, 0);
    chk("A.frozen", 64'(a_cnt), 64'd5);
    cycle(0, 0, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 499) == 0);
    end

    // Saturation: restart A on every idle/done cycle until 300 errors.
    cycle(0, 0, 1);
    issued = 0;
    guard  = 0;
    while (issued < 300 && guard < 20000) begin
      if (!m_a.sweeping) begin
        issued++;
        cycle(1, 1, 0);
      end else begin
        cycle(0, 1, 0);
      end
      guard++;
    end
    chk("A.issued", 64'(issued), 64'd300);
    chk("A.sat255", 64'(a_cnt), 64'd255);
    for (int i = 0; i < 40; i++) cycle(0, 1, 0);
    cycle(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/replay_control.md
# replay_control

Parametrised register-file recovery controller for the fault-tolerant core. On a detected error it walks the architectural register file, issuing `PORTS` replay addresses per beat under a valid/ready handshake, then pulses `done_o`. Errors arriving mid-replay restart the sweep. Exceeding a retry budget locks the block in a sticky fatal state. It sits between the error detector and the register-file copy/write-back path.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: register address width.
- `NUM_REG`, default 2**ADDR_WIDTH: registers to replay; 1 ≤ NUM_REG ≤ 2**ADDR_WIDTH.
- `PORTS`, default 1: addresses issued per beat; 1 ≤ PORTS ≤ NUM_REG.
- `MAX_RETRY`, default 3: in-replay restarts allowed before fatal.
- `CNT_WIDTH`, default 8: width of the error counter.

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `error_i` in 1: error detected; sampled every rising edge.
- `replay_ready_i` in 1: consumer accepts the current beat.
- `replay_valid_o` out 1: beat valid.
- `replay_addr_o` out PORTS*ADDR_WIDTH: lane k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `replay_en_o` out PORTS: per-lane valid within the beat.
- `busy_o` out 1: high in REPLAY.
- `done_o` out 1: one-cycle completion pulse.
- `fatal_o` out 1: sticky retry-budget exhaustion.
- `error_count_o` out CNT_WIDTH: total errors accepted; saturates.

## Operation
- States: IDLE, REPLAY, DONE, FATAL. `rst` forces IDLE and clears all registers.
- Internal registers:
  - `base`: ADDR_WIDTH+1 bits, so it never wraps.
  - `retry`: clog2(MAX_RETRY+1) bits.
  - error counter.
- IDLE:
  - `error_i`=1 → REPLAY with base=0, retry=0, counter+1.
- REPLAY:
  - valid=1.
  - Lane k: addr = base+k, en_k = (base+k < NUM_REG).
  - A lane with en_k=0 drives address 0.
  - Handshake (valid & ready) with no error: base += PORTS.
    - If base+PORTS ≥ NUM_REG, go to DONE.
  - No ready: hold base and all outputs stable.
  - `error_i`=1 with retry < MAX_RETRY: base=0, retry+1, counter+1, stay in REPLAY.
  - `error_i`=1 with retry = MAX_RETRY: go to FATAL, counter+1.
  - Error and handshake in the same cycle: the error wins and the accepted beat is discarded, because base restarts at 0.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - `error_i`=1 in DONE: go directly to REPLAY as a fresh sequence (base=0, retry=0, counter+1). done_o still pulses in that cycle.
- FATAL:
  - fatal_o=1, valid=0.
  - `error_i` is ignored and the counter is frozen.
  - Only `rst` exits.
- Error counter saturates at 2**CNT_WIDTH−1.
- Partial last beat: when NUM_REG is not a multiple of PORTS, the final beat has its high lanes disabled.

## Timing
- Reset values: valid, addr, en, busy, done, fatal, error_count all 0.
- Outputs decode from registered state and base only. There is no combinational path from `error_i` or `replay_ready_i` to any output.
- Error sampled at edge N: first beat (base 0) is visible in cycle N+1.
- With ready held high:
  - Beats = ceil(NUM_REG/PORTS), one per cycle.
  - done_o is high in the cycle after the last beat.
  - PORTS=1, NUM_REG=32: addresses 0..31 in cycles N+1..N+32, done_o in N+33, busy_o low from N+33.
- Each stall cycle (ready=0) adds one cycle of latency.
- Restart error at edge M: base-0 beat reappears in cycle M+1.
- `rst` mid-REPLAY: IDLE and all outputs 0 on the next cycle; no done_o pulse.

## Test plan
- **Single-lane sweep.** Defaults, ready=1, 1-cycle error pulse → addresses 0..31 on consecutive cycles, en=1, one done_o pulse one cycle after address 31, error_count_o=1.
- **Multi-lane, partial last beat.** PORTS=3, NUM_REG=32, ready=1 → 11 beats; last beat has lanes {30,31,0} with en=3'b011; done_o the following cycle.
- **Backpressure.** Ready toggles 1/0 each cycle → each address is presented until accepted, none skipped or repeated; done_o is delayed by the stall count.
- **Restart.** Error re-asserted while address 10 is presented with ready=1 → next beat is address 0, error_count_o=2, full sweep completes, one done_o.
- **Fatal.** MAX_RETRY=3 and 4 in-replay errors → after the 4th, fatal_o=1, valid=0, error_count_o=5. Further errors are ignored; `rst` clears everything to 0.
- **Boundary cases.**
  - Error coincident with the DONE cycle → done_o pulses and a new sweep starts at 0 with retry=0.
  - `rst` mid-sweep → all outputs 0 next cycle.
  - 300 errors with CNT_WIDTH=8 → counter holds at 255.
